// File: rtl/llc_input_sched_pkg.sv
// Shared types and default sizing for the LLC input scheduler.
// Covers the conflict-replay FSM states, the set/count widths and the fairness/watchdog limits.
package llc_input_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPLAY = 2'd2
    } llc_sched_state_t;

    localparam int unsigned LLC_SET_BITS       = 8;
    localparam int unsigned LLC_REQS_BITS_P1   = 5;
    localparam int unsigned LLC_MAX_RSP_STREAK = 8;
    localparam int unsigned LLC_WDOG_CYCLES    = 4096;

endpackage

// File: rtl/llc_rsp_fairness_ctr.sv
// Response-streak counter: after MAX_RSP_STREAK responses are accepted while a request waits,
// response valid is withheld for one slot so the waiting request gets through.
module llc_rsp_fairness_ctr
    import llc_input_sched_pkg::*;
#(
    parameter int unsigned CNT_BITS       = LLC_REQS_BITS_P1,
    parameter int unsigned MAX_RSP_STREAK = LLC_MAX_RSP_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                decode_en,
    input  logic                llc_rsp_in_valid_int,
    input  logic                llc_req_in_valid_int,
    input  logic                set_conflict,
    input  logic [CNT_BITS-1:0] mshr_cnt,
    input  logic                evict_stall,
    input  logic                do_get_rsp_next,
    input  logic                do_get_req_next,
    output logic                rsp_valid_gated
);

    localparam int unsigned STREAK_W = $clog2(MAX_RSP_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RSP_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                starve_q;
    logic                starve_d;
    logic                req_waiting_s;

    // A replay counts as a waiting request even though the decoder serves it ahead of a new one.
    assign req_waiting_s = (llc_req_in_valid_int || set_conflict) &&
                           (mshr_cnt != {CNT_BITS{1'b0}}) && !evict_stall;

    // Streak next-state: reset on any request grant, count responses only while a request waits.
    always_comb begin
        streak_d = streak_q;
        if (decode_en && do_get_req_next) begin
            streak_d = {STREAK_W{1'b0}};
        end else if (decode_en && do_get_rsp_next && req_waiting_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end else begin
            streak_d = streak_q;
        end
        starve_d = (streak_d == STREAK_MAX);
    end

    // Streak and starve registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= {STREAK_W{1'b0}};
            starve_q <= 1'b0;
        end else begin
            streak_q <= streak_d;
            starve_q <= starve_d;
        end
    end

    assign rsp_valid_gated = llc_rsp_in_valid_int && !(starve_q && req_waiting_s);

endmodule

// File: rtl/llc_input_sched.sv
// LLC input scheduler: owns replay of the single set-conflicted request (IDLE/WAIT/REPLAY)
// with a WAIT watchdog, and gates response valid for request/response fairness.
module llc_input_sched
    import llc_input_sched_pkg::*;
#(
    parameter int unsigned SET_BITS       = LLC_SET_BITS,
    parameter int unsigned CNT_BITS       = LLC_REQS_BITS_P1,
    parameter int unsigned MAX_RSP_STREAK = LLC_MAX_RSP_STREAK,
    parameter int unsigned WDOG_CYCLES    = LLC_WDOG_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                decode_en,
    input  logic                llc_rsp_in_valid_int,
    input  logic                llc_req_in_valid_int,
    input  logic [CNT_BITS-1:0] mshr_cnt,
    input  logic                evict_stall,
    input  logic                do_get_rsp_next,
    input  logic                do_get_req_next,
    input  logic                set_req_from_conflict,
    input  logic                conflict_hit,
    input  logic [SET_BITS-1:0] conflict_set,
    input  logic                retire_valid,
    input  logic [SET_BITS-1:0] retire_set,
    output logic                rsp_valid_gated,
    output logic                set_conflict,
    output logic                req_backup_hold,
    output logic                watchdog_err,
    output logic                protocol_err
);

    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    llc_sched_state_t    state_q;
    llc_sched_state_t    state_d;
    logic [SET_BITS-1:0] held_set_q;
    logic [SET_BITS-1:0] held_set_d;
    logic [WDOG_W-1:0]   wdog_q;
    logic [WDOG_W-1:0]   wdog_d;
    logic                wdog_err_q;
    logic                wdog_err_d;
    logic                prot_err_q;
    logic                prot_err_d;

    // FSM next-state, held set capture, watchdog count and sticky error flags.
    always_comb begin
        state_d    = state_q;
        held_set_d = held_set_q;
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q || ((state_q == WAIT) && (wdog_q == WDOG_LAST));
        // A second conflict while one is held is a decoder bug; the held request is kept.
        prot_err_d = prot_err_q || (conflict_hit && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (conflict_hit) begin
                    held_set_d = conflict_set;
                    wdog_d     = {WDOG_W{1'b0}};
                    if (retire_valid && (retire_set == conflict_set)) begin
                        state_d = REPLAY;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                wdog_d = (wdog_q == WDOG_LAST) ? wdog_q : (wdog_q + WDOG_W'(1));
                if (retire_valid && (retire_set == held_set_q)) begin
                    state_d = REPLAY;
                end else begin
                    state_d = WAIT;
                end
            end
            REPLAY: begin
                if (decode_en && set_req_from_conflict) begin
                    state_d = IDLE;
                end else begin
                    state_d = REPLAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, held set, watchdog and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            held_set_q <= {SET_BITS{1'b0}};
            wdog_q     <= {WDOG_W{1'b0}};
            wdog_err_q <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_set_q <= held_set_d;
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign set_conflict    = (state_q == REPLAY);
    assign req_backup_hold = (state_q != IDLE);
    assign watchdog_err    = wdog_err_q;
    assign protocol_err    = prot_err_q;

    llc_rsp_fairness_ctr #(
        .CNT_BITS       (CNT_BITS),
        .MAX_RSP_STREAK (MAX_RSP_STREAK)
    ) u_fairness (
        .clk                  (clk),
        .rst                  (rst),
        .decode_en            (decode_en),
        .llc_rsp_in_valid_int (llc_rsp_in_valid_int),
        .llc_req_in_valid_int (llc_req_in_valid_int),
        .set_conflict         (set_conflict),
        .mshr_cnt             (mshr_cnt),
        .evict_stall          (evict_stall),
        .do_get_rsp_next      (do_get_rsp_next),
        .do_get_req_next      (do_get_req_next),
        .rsp_valid_gated      (rsp_valid_gated)
    );

endmodule
